emd_sift_sub: RTL and testbench

//  Sifting-subtract stage of the EMD core. Sits directly downstream of the 120-sample input delay line.
//  Per sample it forms the envelope mean m=(ENV_U+ENV_L)>>>1 and the candidate IMF h=XD-m.

---
 rtl/emd_sift_sub.sv | 129 ++++++++++++
 tb/tb_emd_sift_sub.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/emd_sift_sub.sv
// EMD sifting-subtract stage: envelope mean, candidate IMF, and per-frame
// stop-criterion energies (sum m^2 vs. sum h^2) for the sifting controller.
module emd_sift_sub #(
  parameter int FRAME_LEN = 120,
  parameter int ACC_W     = 40,
  parameter int SD_SHIFT  = 2
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    SYNC_CLR,
  input  logic                    IN_VALID,
  input  logic signed [15:0]      XD,
  input  logic signed [15:0]      ENV_U,
  input  logic signed [15:0]      ENV_L,
  output logic signed [15:0]      H_OUT,
  output logic signed [15:0]      MEAN_OUT,
  output logic                    H_VALID,
  output logic                    FRAME_DONE,
  output logic        [ACC_W-1:0] SD_NUM,
  output logic        [ACC_W-1:0] SD_DEN,
  output logic                    CONVERGED
);

  localparam int CNT_W = $clog2(FRAME_LEN);
  localparam int CMP_W = ACC_W + SD_SHIFT;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  function automatic logic signed [15:0] sat16(input logic signed [16:0] d);
    if (d > 17'sd32767)
      return 16'sh7fff;
    else if (d < -17'sd32768)
      return 16'sh8000;
    else
      return d[15:0];
  endfunction

  // Square via magnitude so that (-32768)^2 = 2^30 is exact.
  function automatic logic [ACC_W-1:0] sq(input logic signed [15:0] a);
    logic [15:0] mag;
    mag = a[15] ? 16'(-a) : a;
    return ACC_W'(32'(mag) * 32'(mag));
  endfunction

  logic signed [16:0]      sum_p1;
  logic signed [15:0]      xd_p1;
  logic                    vld_p1;
  logic signed [15:0]      mean_p1;
  logic signed [16:0]      diff_p1;
  logic        [ACC_W-1:0] acc_n, acc_d;
  logic        [CNT_W-1:0] cnt;
  logic        [ACC_W-1:0] num_nx, den_nx;
  logic                    conv_nx;

  // Stage 1: envelope sum and aligned sample
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sum_p1 <= '0;
      xd_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= IN_VALID & ~SYNC_CLR;
      if (IN_VALID) begin
        sum_p1 <= 17'(ENV_U) + 17'(ENV_L);
        xd_p1  <= XD;
      end
    end
  end

  always_comb begin
    mean_p1 = 16'(sum_p1 >>> 1);
    diff_p1 = 17'(xd_p1) - 17'(mean_p1);
  end

  // Stage 2: mean and saturated h
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      H_OUT    <= '0;
      MEAN_OUT <= '0;
      H_VALID  <= 1'b0;
    end else begin
      H_VALID <= vld_p1 & ~SYNC_CLR;
      if (vld_p1 && !SYNC_CLR) begin
        H_OUT    <= sat16(diff_p1);
        MEAN_OUT <= mean_p1;
      end
    end
  end

  always_comb begin
    num_nx  = acc_n + sq(MEAN_OUT);
    den_nx  = acc_d + sq(H_OUT);
    conv_nx = ((CMP_W'(num_nx) << SD_SHIFT) <= CMP_W'(den_nx));
  end

  // Frame accumulation and stop-criterion publish
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_n      <= '0;
      acc_d      <= '0;
      cnt        <= '0;
      SD_NUM     <= '0;
      SD_DEN     <= '0;
      CONVERGED  <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      if (SYNC_CLR) begin
        acc_n <= '0;
        acc_d <= '0;
        cnt   <= '0;
      end else if (H_VALID) begin
        if (cnt == LAST) begin
          SD_NUM     <= num_nx;
          SD_DEN     <= den_nx;
          CONVERGED  <= conv_nx;
          FRAME_DONE <= 1'b1;
          acc_n      <= '0;
          acc_d      <= '0;
          cnt        <= '0;
        end else begin
          acc_n <= num_nx;
          acc_d <= den_nx;
          cnt   <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_emd_sift_sub.sv
// Directed bench for emd_sift_sub: per-sample arithmetic table plus frame,
// back-to-back, reset and abort sequences.
module tb_emd_sift_sub;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic               SYNC_CLR = 1'b0;
  logic               IN_VALID = 1'b0;
  logic signed [15:0] XD = '0, ENV_U = '0, ENV_L = '0;
  logic signed [15:0] H_OUT, MEAN_OUT;
  logic               H_VALID, FRAME_DONE, CONVERGED;
  logic        [39:0] SD_NUM, SD_DEN;

  emd_sift_sub #(.FRAME_LEN(120), .ACC_W(40), .SD_SHIFT(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .SYNC_CLR(SYNC_CLR), .IN_VALID(IN_VALID),
    .XD(XD), .ENV_U(ENV_U), .ENV_L(ENV_L),
    .H_OUT(H_OUT), .MEAN_OUT(MEAN_OUT), .H_VALID(H_VALID), .FRAME_DONE(FRAME_DONE),
    .SD_NUM(SD_NUM), .SD_DEN(SD_DEN), .CONVERGED(CONVERGED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic signed [15:0] xd, u, l, mean, h;
  } vec_t;

  typedef struct {
    int     cyc;
    longint num, den;
    int     conv;
  } ev_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  ev_t  evq[$];
  vec_t vecs[6];
  int   c0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock; samples outputs at the falling edge and logs FRAME_DONE pulses.
  task automatic tick();
    ev_t e;
    @(negedge CLK);
    cyc++;
    if (FRAME_DONE) begin
      e.cyc = cyc; e.num = SD_NUM; e.den = SD_DEN; e.conv = CONVERGED;
      evq.push_back(e);
    end
  endtask

  task automatic drive(input logic v, input int xd, input int u, input int l);
    IN_VALID = v; XD = 16'(xd); ENV_U = 16'(u); ENV_L = 16'(l);
    tick();
  endtask

  task automatic idle(input int n);
    IN_VALID = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_event(input string name, input int idx, input int exp_cyc,
                             input longint num, input longint den, input int conv);
    if (evq.size() <= idx) begin
      check({name, "_present"}, evq.size(), idx + 1);
    end else begin
      check({name, "_cycle"}, evq[idx].cyc, exp_cyc);
      check({name, "_num"},   evq[idx].num, num);
      check({name, "_den"},   evq[idx].den, den);
      check({name, "_conv"},  evq[idx].conv, conv);
    end
  endtask

  initial begin
    vecs[0] = '{xd: 1000,   u: 400,    l: 200,    mean: 300,    h: 700};
    vecs[1] = '{xd: 0,      u: 3,      l: -4,     mean: -1,     h: 1};
    vecs[2] = '{xd: 32767,  u: -32768, l: -32768, mean: -32768, h: 32767};
    vecs[3] = '{xd: -32768, u: 32767,  l: 32767,  mean: 32767,  h: -32768};
    vecs[4] = '{xd: -5,     u: -7,     l: 0,      mean: -4,     h: -1};
    vecs[5] = '{xd: 0,      u: 0,      l: 0,      mean: 0,      h: 0};

    // Power-on reset
    tick(); tick();
    check("rst_h_valid", H_VALID, 0);
    check("rst_h_out", H_OUT, 0);
    check("rst_sd_den", SD_DEN, 0);
    check("rst_conv", CONVERGED, 0);
    RST_N = 1'b1;
    tick();

    // Per-sample arithmetic and two-cycle latency
    foreach (vecs[k]) begin
      drive(1'b1, vecs[k].xd, vecs[k].u, vecs[k].l);
      IN_VALID = 1'b0;
      check($sformatf("v%0d_lat1_valid", k), H_VALID, 0);
      tick();
      check($sformatf("v%0d_valid", k), H_VALID, 1);
      check($sformatf("v%0d_mean", k), MEAN_OUT, vecs[k].mean);
      check($sformatf("v%0d_h", k), H_OUT, vecs[k].h);
      tick();
      check($sformatf("v%0d_hold_valid", k), H_VALID, 0);
      check($sformatf("v%0d_hold_h", k), H_OUT, vecs[k].h);
    end

    // Discard the partial frame left by the table vectors
    SYNC_CLR = 1'b1; tick(); SYNC_CLR = 1'b0;
    idle(2);
    evq.delete();

    // Non-converged frame followed back-to-back by a converged frame
    c0 = cyc;
    for (int i = 0; i < 120; i++) drive(1'b1, 100, 100, 100);
    for (int i = 0; i < 120; i++) drive(1'b1, 100, 20, -20);
    idle(6);
    check("b2b_events", evq.size(), 2);
    check_event("b2b_f1", 0, c0 + 122, 1200000, 0, 0);
    check_event("b2b_f2", 1, c0 + 242, 0, 1200000, 1);

    // Asynchronous reset in the middle of a frame
    for (int i = 0; i < 50; i++) drive(1'b1, 100, 20, -20);
    #2 RST_N = 1'b0;
    #1;
    check("arst_h_out", H_OUT, 0);
    check("arst_h_valid", H_VALID, 0);
    check("arst_sd_den", SD_DEN, 0);
    check("arst_conv", CONVERGED, 0);
    idle(1);
    RST_N = 1'b1;
    tick();
    evq.delete();

    // First frame after reset must start counting from zero
    c0 = cyc;
    for (int i = 0; i < 120; i++) drive(1'b1, 100, 20, -20);
    IN_VALID = 1'b0;
    tick();
    check("post_rst_sd_den_held", SD_DEN, 0);
    check("post_rst_last_valid", H_VALID, 1);
    check("post_rst_no_early_done", FRAME_DONE, 0);
    tick();
    check("post_rst_done", FRAME_DONE, 1);
    tick();
    check("post_rst_done_pulse", FRAME_DONE, 0);
    idle(4);
    check("post_rst_events", evq.size(), 1);
    check_event("post_rst", 0, c0 + 122, 0, 1200000, 1);
    evq.delete();

    // Abort: 60 samples with 30 gaps, SYNC_CLR, then a clean frame
    for (int i = 0; i < 90; i++) drive(i % 3 != 0, 100, 100, 100);
    IN_VALID = 1'b0; SYNC_CLR = 1'b1;
    tick();
    SYNC_CLR = 1'b0;
    check("abort_h_valid", H_VALID, 0);
    check("abort_sd_num_held", SD_NUM, 0);
    check("abort_sd_den_held", SD_DEN, 1200000);
    check("abort_conv_held", CONVERGED, 1);
    c0 = cyc;
    for (int i = 0; i < 120; i++) drive(1'b1, 100, 20, -20);
    idle(6);
    check("abort_events", evq.size(), 1);
    check_event("abort_frame", 0, c0 + 122, 0, 1200000, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
